duck_round_tracker: RTL and testbench

Parametrised round/score keeper for the duck-hunt game. It accepts one "bird finished" event per bird from the movement/firing logic and maintains the per-round bird map and the hit and escape counts. It keeps the score as packed BCD, updated serially one digit per cycle, so the top level drives the seven-segment displays without divide/modulo logic. It also advances the round and raises game-over. It sits between the firing datapath (event source) and the HEX/LEDR display logic.

---
 rtl/duck_round_tracker_if.sv | 38 +++
 rtl/duck_round_tracker.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_duck_round_tracker.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/duck_round_tracker_if.sv
// -----------------------------------------------------------------------------
// duck_round_tracker_if
//
// Handshake bundle for the "bird finished" events that the firing datapath
// sends to the round tracker.
//
//   ev_valid   source -> tracker   an event is offered this cycle
//   ev_ready   tracker -> source   tracker can accept an event this cycle
//   ev_hit     source -> tracker   bird was shot (qualified by ev_valid)
//   ev_escape  source -> tracker   bird escaped (qualified by ev_valid)
//
// An event transfers on a rising clock edge where ev_valid and ev_ready are
// both high.
// -----------------------------------------------------------------------------
interface duck_round_tracker_if;

    logic ev_valid;
    logic ev_ready;
    logic ev_hit;
    logic ev_escape;

    // Event source (movement / firing logic)
    modport master (
        output ev_valid,
        output ev_hit,
        output ev_escape,
        input  ev_ready
    );

    // Event sink (round tracker)
    modport slave (
        input  ev_valid,
        input  ev_hit,
        input  ev_escape,
        output ev_ready
    );

endinterface

// File: rtl/duck_round_tracker.sv
// -----------------------------------------------------------------------------
// duck_round_tracker
//
// Round and score keeper for the duck-hunt game. Each accepted "bird
// finished" event updates the per-round bird map and the hit/escape counts,
// then adjusts a packed-BCD score one digit per cycle, so the display logic
// can drive the seven-segment digits directly. When a round is complete the
// block either advances the round (enough hits) or raises a sticky game-over.
//
// Ports
//   clk          single clock
//   reset        asynchronous, active-high reset
//   ev           event handshake (slave side): ev_valid, ev_ready, ev_hit,
//                ev_escape
//   bird_map     1 = bird not shot yet this round, bit cleared on a hit
//   hits         hits this round
//   misses       escapes this round
//   score_bcd    packed BCD score, digit 0 in [3:0]
//   round        current round, 0-based, saturating
//   round_clear  one-cycle pulse when a round is passed
//   game_over    sticky game-over flag, cleared only by reset
//
// Event timing: an event accepted at edge N updates bird_map/hits/misses at
// N, score digit k settles at edge N+1+k, the end-of-round check happens at
// edge N+1+SCORE_DIGITS and ev_ready returns high right after that edge.
// An event with neither flag set goes straight to the check at edge N+1.
// -----------------------------------------------------------------------------
module duck_round_tracker #(
    parameter int   BIRDS_PER_ROUND = 10,
    parameter int   PASS_HITS       = 5,
    parameter int   HIT_POINTS      = 50,
    parameter int   ESCAPE_PENALTY  = 10,
    parameter int   SCORE_DIGITS    = 4,
    parameter int   ROUND_WIDTH     = 4,
    localparam int  CW              = $clog2(BIRDS_PER_ROUND + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    duck_round_tracker_if.slave          ev,
    output logic [BIRDS_PER_ROUND-1:0]   bird_map,
    output logic [CW-1:0]                hits,
    output logic [CW-1:0]                misses,
    output logic [4*SCORE_DIGITS-1:0]    score_bcd,
    output logic [ROUND_WIDTH-1:0]       round,
    output logic                         round_clear,
    output logic                         game_over
);

    localparam int SW = 4 * SCORE_DIGITS;
    localparam int DW = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;

    // Convert a non-negative integer to packed BCD (elaboration time only).
    function automatic logic [SW-1:0] to_bcd(input int value);
        logic [SW-1:0] r;
        int            v;
        r = '0;
        v = value;
        for (int k = 0; k < SCORE_DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    // Largest representable BCD score, used when an add overflows.
    function automatic logic [SW-1:0] all_nines();
        logic [SW-1:0] r;
        r = '0;
        for (int k = 0; k < SCORE_DIGITS; k++) begin
            r[4*k +: 4] = 4'd9;
        end
        return r;
    endfunction

    localparam logic [SW-1:0]          HIT_BCD   = to_bcd(HIT_POINTS);
    localparam logic [SW-1:0]          PEN_BCD   = to_bcd(ESCAPE_PENALTY);
    localparam logic [SW-1:0]          NINES_BCD = all_nines();
    localparam logic [DW-1:0]          LAST_DIG  = DW'(SCORE_DIGITS - 1);
    localparam logic [CW-1:0]          BIRDS_C   = CW'(BIRDS_PER_ROUND);
    localparam logic [CW-1:0]          PASS_C    = CW'(PASS_HITS);
    localparam logic [ROUND_WIDTH-1:0] ROUND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCORE = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_CLR = 2'd2
    } op_t;

    state_t                       state_r;
    state_t                       state_next_s;
    op_t                          op_r;
    logic [SW-1:0]                op_bcd_r;
    logic [DW-1:0]                dig_r;
    logic                         carry_r;
    logic                         ev_ready_r;
    logic [BIRDS_PER_ROUND-1:0]   bird_map_r;
    logic [CW-1:0]                hits_r;
    logic [CW-1:0]                misses_r;
    logic [SW-1:0]                score_bcd_r;
    logic [ROUND_WIDTH-1:0]       round_r;
    logic                         round_clear_r;
    logic                         game_over_r;

    logic                         accept_s;
    logic [CW-1:0]                hm_idx_s;
    logic                         round_full_s;
    logic                         round_pass_s;
    logic [BIRDS_PER_ROUND-1:0]   bird_map_hit_s;
    logic [3:0]                   digit_a_s;
    logic [3:0]                   digit_b_s;
    logic [4:0]                   add_sum_s;
    logic [4:0]                   sub_rhs_s;
    logic [4:0]                   digit_tmp_s;
    logic [3:0]                   digit_res_s;
    logic                         carry_out_s;
    logic [SW-1:0]                score_merge_s;
    logic [SW-1:0]                score_next_s;

    // Round bookkeeping: next bird slot, round completion and pass decision.
    always_comb begin
        hm_idx_s       = hits_r + misses_r;
        round_full_s   = (hm_idx_s == BIRDS_C);
        round_pass_s   = (hits_r >= PASS_C);
        bird_map_hit_s = bird_map_r;
        // The bird that just finished is the next unused slot of the round.
        for (int k = 0; k < BIRDS_PER_ROUND; k++) begin
            bird_map_hit_s[k] = (hm_idx_s == CW'(k)) ? 1'b0 : bird_map_r[k];
        end
    end

    // Serial BCD adder/subtractor for the digit selected by dig_r.
    always_comb begin
        digit_a_s = 4'd0;
        digit_b_s = 4'd0;
        for (int k = 0; k < SCORE_DIGITS; k++) begin
            digit_a_s = (dig_r == DW'(k)) ? score_bcd_r[4*k +: 4] : digit_a_s;
            digit_b_s = (dig_r == DW'(k)) ? op_bcd_r[4*k +: 4]    : digit_b_s;
        end

        add_sum_s = {1'b0, digit_a_s} + {1'b0, digit_b_s} + {4'd0, carry_r};
        sub_rhs_s = {1'b0, digit_b_s} + {4'd0, carry_r};

        case (op_r)
            OP_ADD: begin
                if (add_sum_s > 5'd9) begin
                    digit_tmp_s = add_sum_s - 5'd10;
                    carry_out_s = 1'b1;
                end else begin
                    digit_tmp_s = add_sum_s;
                    carry_out_s = 1'b0;
                end
            end
            OP_SUB: begin
                if ({1'b0, digit_a_s} < sub_rhs_s) begin
                    digit_tmp_s = {1'b0, digit_a_s} + 5'd10 - sub_rhs_s;
                    carry_out_s = 1'b1;
                end else begin
                    digit_tmp_s = {1'b0, digit_a_s} - sub_rhs_s;
                    carry_out_s = 1'b0;
                end
            end
            default: begin
                digit_tmp_s = 5'd0;
                carry_out_s = 1'b0;
            end
        endcase
        digit_res_s = digit_tmp_s[3:0];

        score_merge_s = score_bcd_r;
        for (int k = 0; k < SCORE_DIGITS; k++) begin
            score_merge_s[4*k +: 4] = (dig_r == DW'(k)) ? digit_res_s
                                                         : score_bcd_r[4*k +: 4];
        end

        // A carry out of the top digit means the score overflowed: pin it
        // at all nines. A clear op zeroes everything on its first cycle and
        // the remaining cycles just rewrite zeros.
        case (op_r)
            OP_CLR:  score_next_s = '0;
            OP_ADD:  score_next_s = ((dig_r == LAST_DIG) && carry_out_s) ? NINES_BCD
                                                                          : score_merge_s;
            default: score_next_s = score_merge_s;
        endcase
    end

    // Next-state logic of the event / score / check sequencer.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (ev.ev_valid) begin
                    accept_s = 1'b1;
                    if (ev.ev_escape || ev.ev_hit) begin
                        state_next_s = S_SCORE;
                    end else begin
                        state_next_s = S_CHECK;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_SCORE: begin
                if (dig_r == LAST_DIG) begin
                    state_next_s = S_CHECK;
                end else begin
                    state_next_s = S_SCORE;
                end
            end
            S_CHECK: begin
                if (round_full_s && !round_pass_s) begin
                    state_next_s = S_OVER;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_OVER:  state_next_s = S_OVER;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Sequencer state register; ev_ready is registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            ev_ready_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            ev_ready_r <= (state_next_s == S_IDLE);
        end
    end

    // Round, count, bird-map and score registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r          <= OP_ADD;
            op_bcd_r      <= '0;
            dig_r         <= '0;
            carry_r       <= 1'b0;
            bird_map_r    <= '1;
            hits_r        <= '0;
            misses_r      <= '0;
            score_bcd_r   <= '0;
            round_r       <= '0;
            round_clear_r <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            round_clear_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    dig_r   <= '0;
                    carry_r <= 1'b0;
                    if (accept_s) begin
                        // Escape wins when both flags are set.
                        if (ev.ev_escape) begin
                            misses_r <= misses_r + CW'(1);
                            op_bcd_r <= PEN_BCD;
                            // Score floors at zero: packed BCD orders like binary.
                            op_r     <= (score_bcd_r < PEN_BCD) ? OP_CLR : OP_SUB;
                        end else if (ev.ev_hit) begin
                            hits_r     <= hits_r + CW'(1);
                            bird_map_r <= bird_map_hit_s;
                            op_bcd_r   <= HIT_BCD;
                            op_r       <= OP_ADD;
                        end else begin
                            op_r <= op_r;
                        end
                    end else begin
                        op_r <= op_r;
                    end
                end
                S_SCORE: begin
                    score_bcd_r <= score_next_s;
                    carry_r     <= carry_out_s;
                    dig_r       <= (dig_r == LAST_DIG) ? '0 : dig_r + DW'(1);
                end
                S_CHECK: begin
                    if (round_full_s && round_pass_s) begin
                        bird_map_r    <= '1;
                        hits_r        <= '0;
                        misses_r      <= '0;
                        round_r       <= (round_r == ROUND_MAX) ? round_r
                                                                : round_r + ROUND_WIDTH'(1);
                        round_clear_r <= 1'b1;
                    end else if (round_full_s) begin
                        game_over_r <= 1'b1;
                    end else begin
                        game_over_r <= game_over_r;
                    end
                end
                default: begin
                    game_over_r <= game_over_r;
                end
            endcase
        end
    end

    assign ev.ev_ready   = ev_ready_r;
    assign bird_map      = bird_map_r;
    assign hits          = hits_r;
    assign misses        = misses_r;
    assign score_bcd     = score_bcd_r;
    assign round         = round_r;
    assign round_clear   = round_clear_r;
    assign game_over     = game_over_r;

endmodule

// File: tb/tb_duck_round_tracker.sv
// -----------------------------------------------------------------------------
// tb_duck_round_tracker
//
// Directed bench for duck_round_tracker. Instance A uses the default
// parameters; instance B uses a 4-bird, 2-pass, 3-digit configuration.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_duck_round_tracker;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    duck_round_tracker_if if_a ();
    duck_round_tracker_if if_b ();

    logic [9:0]  a_map;
    logic [3:0]  a_hits;
    logic [3:0]  a_misses;
    logic [15:0] a_score;
    logic [3:0]  a_round;
    logic        a_clear;
    logic        a_over;

    logic [3:0]  b_map;
    logic [2:0]  b_hits;
    logic [2:0]  b_misses;
    logic [11:0] b_score;
    logic [3:0]  b_round;
    logic        b_clear;
    logic        b_over;

    duck_round_tracker dut_a (
        .clk         (clk),
        .reset       (reset),
        .ev          (if_a),
        .bird_map    (a_map),
        .hits        (a_hits),
        .misses      (a_misses),
        .score_bcd   (a_score),
        .round       (a_round),
        .round_clear (a_clear),
        .game_over   (a_over)
    );

    duck_round_tracker #(
        .BIRDS_PER_ROUND (4),
        .PASS_HITS       (2),
        .SCORE_DIGITS    (3)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .ev          (if_b),
        .bird_map    (b_map),
        .hits        (b_hits),
        .misses      (b_misses),
        .score_bcd   (b_score),
        .round       (b_round),
        .round_clear (b_clear),
        .game_over   (b_over)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        hit;
        logic        esc;
        logic [9:0]  map;
        logic [3:0]  h;
        logic [3:0]  m;
        logic [15:0] score;
        logic [3:0]  rnd;
        logic        clr;
        logic        over;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? if_b.ev_ready : if_a.ev_ready;
    endfunction

    function automatic logic over_of(input bit sel);
        return sel ? b_over : a_over;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic h, input logic e);
        if (sel) begin
            if_b.ev_valid = v; if_b.ev_hit = h; if_b.ev_escape = e;
        end else begin
            if_a.ev_valid = v; if_a.ev_hit = h; if_a.ev_escape = e;
        end
    endtask

    // Offer one event, then wait until the tracker is ready again or has
    // stopped with game over. Called and returns on a falling edge.
    task automatic send(input bit sel, input logic h, input logic e);
        int n;
        n = 0;
        while (!rdy(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(sel)) begin
            total++;
            $display("FAIL ready_wait: ev_ready still 0 after %0d cycles, expected 1", n);
        end else begin
            drive(sel, 1'b1, h, e);
            @(negedge clk);
            // Flags are only sampled at the accept edge; scramble them now.
            drive(sel, 1'b0, ~h, ~e);
            n = 0;
            while (!(rdy(sel) || over_of(sel)) && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!(rdy(sel) || over_of(sel))) begin
                total++;
                $display("FAIL done_wait: no ready/game_over after %0d cycles, expected one", n);
            end
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_map"},   32'(a_map),         32'h3FF);
        check({tag, "_hits"},  32'(a_hits),        32'h0);
        check({tag, "_miss"},  32'(a_misses),      32'h0);
        check({tag, "_score"}, 32'(a_score),       32'h0);
        check({tag, "_round"}, 32'(a_round),       32'h0);
        check({tag, "_clear"}, 32'(a_clear),       32'h0);
        check({tag, "_over"},  32'(a_over),        32'h0);
        check({tag, "_ready"}, 32'(if_a.ev_ready), 32'h1);
    endtask

    // Watchdog against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_hi;
        int first_hi;
        int second_hi;

        // hit, esc, map, hits, misses, score, round, round_clear, game_over
        tbl[0]  = '{1'b0, 1'b1, 10'h3FF, 4'd0, 4'd1, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 10'h3FD, 4'd1, 4'd1, 16'h0050, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 10'h3F9, 4'd2, 4'd1, 16'h0100, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 10'h3F1, 4'd3, 4'd1, 16'h0150, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 10'h3F1, 4'd3, 4'd2, 16'h0140, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 10'h3F1, 4'd3, 4'd3, 16'h0130, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 10'h3F1, 4'd3, 4'd3, 16'h0130, 4'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 10'h3B1, 4'd4, 4'd3, 16'h0180, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 10'h331, 4'd5, 4'd3, 16'h0230, 4'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 10'h331, 4'd5, 4'd4, 16'h0220, 4'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 10'h3FF, 4'd0, 4'd0, 16'h0210, 4'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 10'h3FE, 4'd1, 4'd0, 16'h0260, 4'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 10'h3FC, 4'd2, 4'd0, 16'h0310, 4'd1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 10'h3F8, 4'd3, 4'd0, 16'h0360, 4'd1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 10'h3F0, 4'd4, 4'd0, 16'h0410, 4'd1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 10'h3F0, 4'd4, 4'd1, 16'h0400, 4'd1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 10'h3F0, 4'd4, 4'd2, 16'h0390, 4'd1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 10'h3F0, 4'd4, 4'd3, 16'h0380, 4'd1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 10'h3F0, 4'd4, 4'd4, 16'h0370, 4'd1, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 10'h3F0, 4'd4, 4'd5, 16'h0360, 4'd1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 10'h3F0, 4'd4, 4'd6, 16'h0350, 4'd1, 1'b0, 1'b1};

        reset = 1'b1;
        do_reset();
        check_a_reset("rst");
        check("rst_b_map",   32'(b_map),   32'hF);
        check("rst_b_score", 32'(b_score), 32'h0);

        // Timing and throughput: ev_valid held with a hit for 12 cycles
        // accepts exactly two events, six cycles apart.
        ready_hi  = 0;
        first_hi  = -1;
        second_hi = -1;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (if_a.ev_ready) begin
                ready_hi++;
                if (first_hi < 0) first_hi = i;
                else if (second_hi < 0) second_hi = i;
            end
            if (i == 1) begin
                check("t_hits_at_accept", 32'(a_hits), 32'h1);
                check("t_map_at_accept",  32'(a_map),  32'h3FE);
            end
            if (i == 3) begin
                check("t_score_digit1", 32'(a_score), 32'h0050);
            end
            if (i == 11) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0);
            end
            @(negedge clk);
        end
        check("t_ready_windows", 32'(ready_hi), 32'd2);
        check("t_accept_gap",    32'(second_hi - first_hi), 32'd6);
        check("t_ready_back",    32'(if_a.ev_ready), 32'h1);
        check("t_hits_two",      32'(a_hits),  32'h2);
        check("t_map_two",       32'(a_map),   32'h3FC);
        check("t_score_two",     32'(a_score), 32'h0100);

        // Reset pulsed during the second SCORE cycle of a hit.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_a_reset("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_a_reset("postrst");

        // Main table: one event per row from the reset state.
        for (int r = 0; r < 21; r++) begin
            send(1'b0, tbl[r].hit, tbl[r].esc);
            check($sformatf("v%0d_map",   r), 32'(a_map),    32'(tbl[r].map));
            check($sformatf("v%0d_hits",  r), 32'(a_hits),   32'(tbl[r].h));
            check($sformatf("v%0d_miss",  r), 32'(a_misses), 32'(tbl[r].m));
            check($sformatf("v%0d_score", r), 32'(a_score),  32'(tbl[r].score));
            check($sformatf("v%0d_round", r), 32'(a_round),  32'(tbl[r].rnd));
            check($sformatf("v%0d_clear", r), 32'(a_clear),  32'(tbl[r].clr));
            check($sformatf("v%0d_over",  r), 32'(a_over),   32'(tbl[r].over));
            check($sformatf("v%0d_ready", r), 32'(if_a.ev_ready), 32'(!tbl[r].over));
            if (r == 10) begin
                @(negedge clk);
                check("clear_one_cycle", 32'(a_clear), 32'h0);
            end
        end

        // Game over: offered events are ignored and outputs stay frozen.
        ready_hi = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_a.ev_ready) ready_hi++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("over_ready_low", 32'(ready_hi), 32'd0);
        check("over_hits",      32'(a_hits),   32'h4);
        check("over_misses",    32'(a_misses), 32'h6);
        check("over_map",       32'(a_map),    32'h3F0);
        check("over_score",     32'(a_score),  32'h0350);
        check("over_round",     32'(a_round),  32'h1);
        check("over_sticky",    32'(a_over),   32'h1);

        // Saturation: 198 hits, 2 escapes, 2 hits reach 9980; one more hit
        // overflows to 9999. The round counter saturates at 15 on the way.
        do_reset();
        for (int i = 0; i < 198; i++) send(1'b0, 1'b1, 1'b0);
        check("sat_9900", 32'(a_score), 32'h9900);
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        check("sat_9980",   32'(a_score), 32'h9980);
        check("sat_round",  32'(a_round), 32'hF);
        send(1'b0, 1'b1, 1'b0);
        check("sat_9999",   32'(a_score), 32'h9999);
        send(1'b0, 1'b0, 1'b1);
        check("sat_borrow", 32'(a_score), 32'h9989);
        check("sat_over",   32'(a_over),  32'h0);

        // Small configuration: 2 hits + 2 escapes passes the round.
        do_reset();
        send(1'b1, 1'b1, 1'b0);
        check("b_score_50", 32'(b_score), 32'h050);
        check("b_map_hit",  32'(b_map),   32'hE);
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        check("b_score", 32'(b_score),  32'h080);
        check("b_clear", 32'(b_clear),  32'h1);
        check("b_round", 32'(b_round),  32'h1);
        check("b_map",   32'(b_map),    32'hF);
        check("b_hits",  32'(b_hits),   32'h0);
        check("b_miss",  32'(b_misses), 32'h0);
        check("b_over",  32'(b_over),   32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
